// File: rtl/l2_req_responder_if.sv
// L2 request/response channel bundle between the L2 (master) and a memory-side
// responder (slave). Signal names match the L2 port names so benches wire up 1:1.
interface l2_req_responder_if #(
  parameter int WORDS_PER_LINE = 2,
  parameter int BITS_PER_WORD  = 64,
  parameter int LINE_ADDR_BITS = 26
);
  localparam int LINE_W = WORDS_PER_LINE * BITS_PER_WORD;

  logic                      l2_req_out_valid;
  logic                      l2_req_out_ready;
  logic [4:0]                l2_req_out_coh_msg;
  logic                      l2_req_out_hprot;
  logic [LINE_ADDR_BITS-1:0] l2_req_out_addr;
  logic [LINE_W-1:0]         l2_req_out_line;
  logic [WORDS_PER_LINE-1:0] l2_req_out_word_mask;

  logic                      l2_rsp_in_valid;
  logic                      l2_rsp_in_ready;
  logic [4:0]                l2_rsp_in_coh_msg;
  logic [LINE_ADDR_BITS-1:0] l2_rsp_in_addr;
  logic [LINE_W-1:0]         l2_rsp_in_line;
  logic [WORDS_PER_LINE-1:0] l2_rsp_in_word_mask;
  logic [3:0]                l2_rsp_in_invack_cnt;

  modport master (
    output l2_req_out_valid, l2_req_out_coh_msg, l2_req_out_hprot, l2_req_out_addr,
           l2_req_out_line, l2_req_out_word_mask, l2_rsp_in_ready,
    input  l2_req_out_ready, l2_rsp_in_valid, l2_rsp_in_coh_msg, l2_rsp_in_addr,
           l2_rsp_in_line, l2_rsp_in_word_mask, l2_rsp_in_invack_cnt
  );

  modport slave (
    input  l2_req_out_valid, l2_req_out_coh_msg, l2_req_out_hprot, l2_req_out_addr,
           l2_req_out_line, l2_req_out_word_mask, l2_rsp_in_ready,
    output l2_req_out_ready, l2_rsp_in_valid, l2_rsp_in_coh_msg, l2_rsp_in_addr,
           l2_rsp_in_line, l2_rsp_in_word_mask, l2_rsp_in_invack_cnt
  );
endinterface

// File: rtl/l2_req_responder.sv
// Memory-side stand-in for the LLC: serves one L2 request at a time from a
// line-addressed backing store and tracks per-word ownership.
// Flow: IDLE (accept) -> ACCESS (read/write store, build response) -> RESP.
module l2_req_responder #(
  parameter int MEM_LINES      = 256,
  parameter int WORDS_PER_LINE = 2,
  parameter int BITS_PER_WORD  = 64,
  parameter int LINE_ADDR_BITS = 26
) (
  input  logic              clk,
  input  logic              rst,
  l2_req_responder_if.slave bus,
  output logic              err_bad_msg,
  output logic [15:0]       req_cnt
);
  localparam int IDX_W  = $clog2(MEM_LINES);
  localparam int LINE_W = WORDS_PER_LINE * BITS_PER_WORD;

  localparam logic [4:0] REQ_V      = 5'd0;
  localparam logic [4:0] REQ_S      = 5'd1;
  localparam logic [4:0] REQ_O      = 5'd2;
  localparam logic [4:0] REQ_ODATA  = 5'd3;
  localparam logic [4:0] REQ_WT     = 5'd4;
  localparam logic [4:0] REQ_WB     = 5'd5;
  localparam logic [4:0] RSP_V      = 5'd8;
  localparam logic [4:0] RSP_S      = 5'd9;
  localparam logic [4:0] RSP_O      = 5'd10;
  localparam logic [4:0] RSP_ODATA  = 5'd11;
  localparam logic [4:0] RSP_WT     = 5'd12;
  localparam logic [4:0] RSP_WB_ACK = 5'd13;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  state_t r_state, w_next;

  logic [4:0]                r_msg;
  logic [LINE_ADDR_BITS-1:0] r_addr;
  logic [LINE_W-1:0]         r_line;
  logic [WORDS_PER_LINE-1:0] r_mask;

  logic [LINE_W-1:0]         r_mem   [MEM_LINES];
  logic [WORDS_PER_LINE-1:0] r_owned [MEM_LINES];

  logic [4:0]                r_rsp_msg;
  logic [LINE_ADDR_BITS-1:0] r_rsp_addr;
  logic [LINE_W-1:0]         r_rsp_line;
  logic [WORDS_PER_LINE-1:0] r_rsp_mask;
  logic                      r_err;
  logic [15:0]               r_cnt;

  logic                      w_ready, w_req_fire, w_rsp_fire, w_access;
  logic [IDX_W-1:0]          w_idx;
  logic [LINE_W-1:0]         w_rd_line, w_wmask, w_wr_line, w_rsp_line;
  logic [4:0]                w_rsp_msg;
  logic [WORDS_PER_LINE-1:0] w_rsp_mask;
  logic                      w_bad, w_wr_en, w_own_set, w_own_clr;
  logic                      w_unused_hprot;

  // ready is gated by reset so the L2 never sees a ready while rst is held
  assign w_ready        = (r_state == S_IDLE) && rst;
  assign w_req_fire     = bus.l2_req_out_valid && w_ready;
  assign w_rsp_fire     = (r_state == S_RESP) && bus.l2_rsp_in_ready;
  assign w_access       = (r_state == S_ACCESS);
  assign w_idx          = r_addr[IDX_W-1:0];   // upper address bits alias by design
  assign w_rd_line      = r_mem[w_idx];
  assign w_wr_line      = (w_rd_line & ~w_wmask) | (r_line & w_wmask);
  assign w_unused_hprot = bus.l2_req_out_hprot;

  for (genvar w = 0; w < WORDS_PER_LINE; w++) begin : g_wmask
    assign w_wmask[w*BITS_PER_WORD +: BITS_PER_WORD] = {BITS_PER_WORD{r_mask[w]}};
  end

  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;

  // next-state: bad opcodes skip RESP and return straight to IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_req_fire) w_next = S_ACCESS;
      S_ACCESS: w_next = w_bad ? S_IDLE : S_RESP;
      S_RESP:   if (w_rsp_fire) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // opcode decode for the latched request: response contents and store/owned effects
  always_comb begin
    w_bad      = 1'b0;
    w_wr_en    = 1'b0;
    w_own_set  = 1'b0;
    w_own_clr  = 1'b0;
    w_rsp_msg  = 5'd0;
    w_rsp_line = '0;
    w_rsp_mask = r_mask;
    case (r_msg)
      REQ_V:     begin w_rsp_msg = RSP_V; w_rsp_line = w_rd_line & w_wmask; end
      REQ_S:     begin w_rsp_msg = RSP_S; w_rsp_line = w_rd_line; w_rsp_mask = '1; end
      REQ_O:     begin w_rsp_msg = RSP_O; w_own_set = 1'b1; end
      REQ_ODATA: begin w_rsp_msg = RSP_ODATA; w_rsp_line = w_rd_line; w_own_set = 1'b1; end
      REQ_WT:    begin w_rsp_msg = RSP_WT; w_wr_en = 1'b1; end
      REQ_WB:    begin w_rsp_msg = RSP_WB_ACK; w_wr_en = 1'b1; w_own_clr = 1'b1; end
      default:   w_bad = 1'b1;
    endcase
  end

  // request capture and accept counter
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_msg  <= '0;
      r_addr <= '0;
      r_line <= '0;
      r_mask <= '0;
      r_cnt  <= '0;
    end else if (w_req_fire) begin
      r_msg  <= bus.l2_req_out_coh_msg;
      r_addr <= bus.l2_req_out_addr;
      r_line <= bus.l2_req_out_line;
      r_mask <= bus.l2_req_out_word_mask;
      r_cnt  <= r_cnt + 16'd1;
    end

  // response registers load at the end of ACCESS and hold through RESP; sticky error flag
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_rsp_msg  <= '0;
      r_rsp_addr <= '0;
      r_rsp_line <= '0;
      r_rsp_mask <= '0;
      r_err      <= 1'b0;
    end else if (w_access) begin
      if (w_bad) r_err <= 1'b1;
      else begin
        r_rsp_msg  <= w_rsp_msg;
        r_rsp_addr <= r_addr;
        r_rsp_line <= w_rsp_line;
        r_rsp_mask <= w_rsp_mask;
      end
    end

  // per-line owned masks; cleared on reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < MEM_LINES; i++) r_owned[i] <= '0;
    end else if (w_access) begin
      if (w_own_set)      r_owned[w_idx] <= r_owned[w_idx] | r_mask;
      else if (w_own_clr) r_owned[w_idx] <= r_owned[w_idx] & ~r_mask;
    end

  // backing store: no reset so data survives a mid-operation reset
  always_ff @(posedge clk)
    if (r_state == S_ACCESS && w_wr_en) r_mem[w_idx] <= w_wr_line;

  assign bus.l2_req_out_ready     = w_ready;
  assign bus.l2_rsp_in_valid      = (r_state == S_RESP);
  assign bus.l2_rsp_in_coh_msg    = r_rsp_msg;
  assign bus.l2_rsp_in_addr       = r_rsp_addr;
  assign bus.l2_rsp_in_line       = r_rsp_line;
  assign bus.l2_rsp_in_word_mask  = r_rsp_mask;
  assign bus.l2_rsp_in_invack_cnt = 4'd0;
  assign err_bad_msg              = r_err;
  assign req_cnt                  = r_cnt;
endmodule

// File: doc/l2_req_responder.md
# l2_req_responder

Memory-side responder for the L2's request channel. It accepts a single L2 request (`l2_req_out`) and returns the matching response on the L2's response-input channel (`l2_rsp_in`). It serves that request from an internal line-addressed backing store and tracks per-word ownership. It replaces the LLC in L2 unit/integration benches and standalone FPGA bring-up, and sits directly across the L2 request/response ports.

## Interface
- `MEM_LINES`, 256: lines in the backing store (power of two).
- `WORDS_PER_LINE`, 2: words per line, matching the codebase constant.
- `BITS_PER_WORD`, 64: word width.
- `LINE_ADDR_BITS`, 26: line-address width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; one clock; reset is asynchronous and active-low.
- `l2_req_out_valid` in 1: request valid.
- `l2_req_out_ready` out 1: request ready.
- `l2_req_out_coh_msg` in 5: request opcode (`REQ_V`, `REQ_S`, `REQ_O`, `REQ_Odata`, `REQ_WT`, `REQ_WB`; encodings from spandex_consts).
- `l2_req_out_hprot` in 1: hprot; ignored.
- `l2_req_out_addr` in `LINE_ADDR_BITS`: line address.
- `l2_req_out_line` in `WORDS_PER_LINE*BITS_PER_WORD`: write data.
- `l2_req_out_word_mask` in `WORDS_PER_LINE`: words addressed.
- `l2_rsp_in_valid` out 1: response valid.
- `l2_rsp_in_ready` in 1: response ready.
- `l2_rsp_in_coh_msg` out 5: response opcode.
- `l2_rsp_in_addr` out `LINE_ADDR_BITS`: echoed line address.
- `l2_rsp_in_line` out `WORDS_PER_LINE*BITS_PER_WORD`: read data.
- `l2_rsp_in_word_mask` out `WORDS_PER_LINE`: echoed word mask.
- `l2_rsp_in_invack_cnt` out 4: always 0.
- `err_bad_msg` out 1: sticky flag; an unsupported opcode was seen.
- `req_cnt` out 16: requests accepted; wraps at 2^16.

## Operation
- Store: `MEM_LINES` lines, indexed by `addr[log2(MEM_LINES)-1:0]`. Upper address bits are ignored, so aliasing is intended.
  - Data is not reset.
  - Per-line owned mask (`WORDS_PER_LINE` bits) is cleared on reset.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: `l2_req_out_ready`=1. On valid&ready: latch all request fields, `req_cnt`++, go to ACCESS.
  - ACCESS: `ready`=0. Synchronous store read; apply writes; build response; go to RESP.
  - RESP: `l2_rsp_in_valid`=1 with stable fields until `l2_rsp_in_ready`=1. On that handshake: go to IDLE.
- Opcode actions (response addr/word_mask echo the request; unused data words are 0):
  - `REQ_V` → `RSP_V`: masked words from store.
  - `REQ_S` → `RSP_S`: full line; mask forced all-ones in response.
  - `REQ_O` → `RSP_O`: line 0; owned |= mask.
  - `REQ_Odata` → `RSP_Odata`: full line; owned |= mask.
  - `REQ_WT` → `RSP_WT`: store masked words; owned unchanged; line 0.
  - `REQ_WB` → `RSP_WB_ACK`: store masked words; owned &= ~mask; line 0.
  - Any other opcode: no store or owned update, no response. Set `err_bad_msg`; go ACCESS → IDLE.
- Word mask 0: still responds with the mapped opcode; no store change.
- Write and read of the same line in one request never occur (no opcode does both).

## Timing
- Reset values:
  - `l2_req_out_ready`=0 during reset, 1 in the first cycle after deassertion (IDLE).
  - `l2_rsp_in_valid`=0; all rsp fields 0.
  - `err_bad_msg`=0, `req_cnt`=0, FSM=IDLE.
- Latency: request handshake in cycle N → `l2_rsp_in_valid` high in cycle N+2.
- Minimum spacing: 3 cycles per request; next request accepted in cycle N+3 if the response is taken in N+2.
- Store write commits at the end of ACCESS. A following request to the same line sees the new data.
- Response fields hold while `valid`&!`ready` (backpressure of any length). `valid` never drops without a handshake, except on reset.
- Reset asserted mid-operation: immediate async return to IDLE; `valid`=0; any response in flight is lost.
  - A write completed in an earlier ACCESS persists.
  - The owned mask clears.
- `err_bad_msg` clears only on reset.

## Test plan
- Reset, then `REQ_WT` addr 0x10, mask 2'b11, line {64'hA, 64'hB}: `RSP_WT` at handshake+2. Then `REQ_V` addr 0x10, mask 2'b01 → `RSP_V`, line {0, 64'hB}, mask 2'b01.
- `REQ_Odata` addr 0x5 mask 2'b10: `RSP_Odata` with full stored line, owned[5]=2'b10. Then `REQ_WB` mask 2'b10 data {64'hC,0}: `RSP_WB_ACK`, owned[5]=0, later `REQ_S` returns {64'hC, old word0}, mask 2'b11.
- Hold `l2_rsp_in_ready`=0 for 10 cycles after `REQ_S`: `valid` and all fields stable for the whole period, `l2_req_out_ready`=0. Raise ready: next request accepted the following cycle.
- Alias: `REQ_WT` to addr 0x100+3 with MEM_LINES=256, then `REQ_V` addr 3 → returns the written data.
- Opcode 5'h1F: no response, `err_bad_msg`=1, `req_cnt` incremented, `ready` back to 1 two cycles after acceptance. Subsequent `REQ_V` is served normally.
- Assert `rst` during RESP: `valid` drops asynchronously. After release: IDLE, `req_cnt`=0, owned masks 0, earlier written data still readable.
